// File: rtl/forwarding_unit.sv
// Operand bypass selection and load-use stall detection for the execute stage,
// with a saturating stall-cycle counter for performance monitoring.

module fwd_operand #(
    parameter int VLEN     = 128,
    parameter int REG_BITS = 5
) (
    input  logic [REG_BITS-1:0] rs,
    input  logic [REG_BITS-1:0] rd_mem,
    input  logic [REG_BITS-1:0] rd_wb,
    input  logic                write_enable_mem,
    input  logic                write_enable_wb,
    input  logic                wb_sel,
    input  logic [VLEN-1:0]     result_mem,
    input  logic [VLEN-1:0]     result_wb,
    output logic                mem_hit,
    output logic                fwd,
    output logic [VLEN-1:0]     vres
);
    logic wb_hit;

    assign mem_hit = write_enable_mem && (rd_mem == rs);
    assign wb_hit  = write_enable_wb && (rd_wb == rs);

    // A memory-stage load hit falls through to writeback; the stall covers it.
    always_comb begin
        fwd  = 1'b0;
        vres = '0;
        if (mem_hit && wb_sel) begin
            fwd  = 1'b1;
            vres = result_mem;
        end else if (wb_hit) begin
            fwd  = 1'b1;
            vres = result_wb;
        end
    end
endmodule

module forwarding_unit #(
    parameter int XLEN     = 32,
    parameter int VLEN     = 128,
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_sel,
    input  logic                write_enable_mem,
    input  logic                write_enable_wb,
    input  logic [REG_BITS-1:0] rs1_ex,
    input  logic [REG_BITS-1:0] rs2_ex,
    input  logic [REG_BITS-1:0] rd_mem,
    input  logic [REG_BITS-1:0] rd_wb,
    input  logic [VLEN-1:0]     result_mem,
    input  logic [VLEN-1:0]     result_wb,
    output logic                stall,
    output logic                OpAForward,
    output logic                OpBForward,
    output logic [XLEN-1:0]     resultA,
    output logic [XLEN-1:0]     resultB,
    output logic [VLEN-1:0]     vresultA,
    output logic [VLEN-1:0]     vresultB,
    output logic [CNT_BITS-1:0] stall_count
);
    localparam int NUM_OPS = 2;

    logic [NUM_OPS-1:0][REG_BITS-1:0] rs;
    logic [NUM_OPS-1:0]               mem_hit;
    logic [NUM_OPS-1:0]               fwd;
    logic [NUM_OPS-1:0][VLEN-1:0]     vres;

    // Slot 0 is operand A, slot 1 is operand B.
    assign rs = {rs2_ex, rs1_ex};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        fwd_operand #(
            .VLEN     (VLEN),
            .REG_BITS (REG_BITS)
        ) u_op (
            .rs               (rs[i]),
            .rd_mem           (rd_mem),
            .rd_wb            (rd_wb),
            .write_enable_mem (write_enable_mem),
            .write_enable_wb  (write_enable_wb),
            .wb_sel           (wb_sel),
            .result_mem       (result_mem),
            .result_wb        (result_wb),
            .mem_hit          (mem_hit[i]),
            .fwd              (fwd[i]),
            .vres             (vres[i])
        );
    end

    assign stall      = (|mem_hit) && !wb_sel;
    assign OpAForward = fwd[0];
    assign OpBForward = fwd[1];
    assign vresultA   = vres[0];
    assign vresultB   = vres[1];
    assign resultA    = vres[0][XLEN-1:0];
    assign resultB    = vres[1][XLEN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (stall && (stall_count != {CNT_BITS{1'b1}}))
            stall_count <= stall_count + 1'b1;
    end
endmodule

// File: tb/tb_forwarding_unit.sv
// Directed bench for forwarding_unit: bypass selection, load-use stall and
// the saturating stall counter with asynchronous reset.

module tb_forwarding_unit;
    logic         clk = 1'b0;
    logic         rst;
    logic         wb_sel, write_enable_mem, write_enable_wb;
    logic [4:0]   rs1_ex, rs2_ex, rd_mem, rd_wb;
    logic [127:0] result_mem, result_wb;
    logic         stall, OpAForward, OpBForward;
    logic [31:0]  resultA, resultB;
    logic [127:0] vresultA, vresultB;
    logic [15:0]  stall_count;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] RM = 128'h1234567890ABCDEF;
    localparam logic [127:0] RW = 128'hFEDCBA0987654321;

    forwarding_unit #(.XLEN(32), .VLEN(128), .REG_BITS(5), .CNT_BITS(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .wb_sel           (wb_sel),
        .write_enable_mem (write_enable_mem),
        .write_enable_wb  (write_enable_wb),
        .rs1_ex           (rs1_ex),
        .rs2_ex           (rs2_ex),
        .rd_mem           (rd_mem),
        .rd_wb            (rd_wb),
        .result_mem       (result_mem),
        .result_wb        (result_wb),
        .stall            (stall),
        .OpAForward       (OpAForward),
        .OpBForward       (OpBForward),
        .resultA          (resultA),
        .resultB          (resultB),
        .vresultA         (vresultA),
        .vresultB         (vresultB),
        .stall_count      (stall_count)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        wb_sel = 1'b1; write_enable_mem = 1'b1; write_enable_wb = 1'b1;
        rs1_ex = 5'd1; rs2_ex = 5'd2; rd_mem = 5'd3; rd_wb = 5'd4;
        result_mem = RM; result_wb = RW;
        #1;
        checks++;
        if (stall_count !== 16'd0) begin
            errors++; $display("FAIL reset_count: got %h want 0", stall_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_no_hazard();
        #1;
        checks++;
        if ({stall, OpAForward, OpBForward} !== 3'b000) begin
            errors++; $display("FAIL no_hazard_flags: got %b want 000", {stall, OpAForward, OpBForward});
        end
        checks++;
        if ({vresultA, vresultB, resultA, resultB} !== '0) begin
            errors++; $display("FAIL no_hazard_results: got %h %h want 0", vresultA, vresultB);
        end
    endtask

    task automatic test_mem_fwd();
        rs1_ex = 5'd3;
        #1;
        checks++;
        if ({OpAForward, resultA, vresultA} !== {1'b1, 32'h90ABCDEF, RM}) begin
            errors++; $display("FAIL mem_fwd_A: got %b %h %h want 1 90abcdef %h", OpAForward, resultA, vresultA, RM);
        end
    endtask

    task automatic test_wb_fwd();
        rs2_ex = 5'd4;
        #1;
        checks++;
        if ({OpBForward, resultB, vresultB} !== {1'b1, 32'h87654321, RW}) begin
            errors++; $display("FAIL wb_fwd_B: got %b %h %h want 1 87654321 %h", OpBForward, resultB, vresultB, RW);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        wb_sel = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL load_use_stall: got %b want 1", stall);
        end
        checks++;
        if ({OpAForward, resultA} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL load_use_A: got %b %h want 0 0", OpAForward, resultA);
        end
        checks++;
        if ({OpBForward, resultB} !== {1'b1, 32'h87654321}) begin
            errors++; $display("FAIL load_use_B: got %b %h want 1 87654321", OpBForward, resultB);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall_count !== 16'd3) begin
            errors++; $display("FAIL load_use_count: got %0d want 3", stall_count);
        end
        wb_sel = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL load_use_release: got %b want 0", stall);
        end
        @(negedge clk);
        checks++;
        if (stall_count !== 16'd3) begin
            errors++; $display("FAIL count_hold: got %0d want 3", stall_count);
        end
    endtask

    task automatic test_we_gating();
        write_enable_mem = 1'b0;
        rs1_ex = 5'd3;
        #1;
        checks++;
        if (OpAForward !== 1'b0) begin
            errors++; $display("FAIL we_mem_gate_A: got %b want 0", OpAForward);
        end
        rs2_ex = 5'd17; rd_wb = 5'd17;
        #1;
        checks++;
        if ({OpBForward, vresultB} !== {1'b1, RW}) begin
            errors++; $display("FAIL wb_fwd_17: got %b %h want 1 %h", OpBForward, vresultB, RW);
        end
        rd_mem = 5'd17;
        #1;
        checks++;
        if ({OpBForward, vresultB} !== {1'b1, RW}) begin
            errors++; $display("FAIL we_mem_gate_B: got %b %h want 1 %h", OpBForward, vresultB, RW);
        end
        wb_sel = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL we_mem_gate_stall: got %b want 0", stall);
        end
        wb_sel = 1'b1;
        #1;
    endtask

    task automatic test_priority();
        write_enable_mem = 1'b1;
        #1;
        checks++;
        if (vresultB !== RM) begin
            errors++; $display("FAIL prio_mem_over_wb: got %h want %h", vresultB, RM);
        end
        write_enable_wb = 1'b0;
        #1;
        checks++;
        if ({OpBForward, vresultB} !== {1'b1, RM}) begin
            errors++; $display("FAIL prio_wb_off: got %b %h want 1 %h", OpBForward, vresultB, RM);
        end
    endtask

    task automatic test_reg_zero();
        logic [127:0] wide;
        wide = 128'hA5A5_1111_2222_3333_4444_5555_CAFE_F00D;
        result_mem = wide;
        rs1_ex = 5'd0; rs2_ex = 5'd0; rd_mem = 5'd0;
        #1;
        checks++;
        if ({OpAForward, OpBForward, vresultA, vresultB} !== {2'b11, wide, wide}) begin
            errors++; $display("FAIL reg0_fwd: got %b%b %h %h want 11 %h", OpAForward, OpBForward, vresultA, vresultB, wide);
        end
        checks++;
        if ({resultA, resultB} !== {32'hCAFEF00D, 32'hCAFEF00D}) begin
            errors++; $display("FAIL reg0_scalar: got %h %h want cafef00d", resultA, resultB);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        wb_sel = 1'b0;
        repeat (65539) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall_count !== 16'hFFFF) begin
            errors++; $display("FAIL saturate: got %h want ffff", stall_count);
        end
    endtask

    task automatic test_async_reset();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (stall_count !== 16'd0) begin
            errors++; $display("FAIL async_reset: got %h want 0", stall_count);
        end
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL stall_in_reset: got %b want 1", stall);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_count !== 16'd1) begin
            errors++; $display("FAIL resume_count: got %0d want 1", stall_count);
        end
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_mem_fwd();
        test_wb_fwd();
        test_load_use();
        test_we_gating();
        test_priority();
        test_reg_zero();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
